// File: rtl/fetch_unit_if.sv
// Memory read bus and decoder handshake of the instruction fetch stage.
// master = fetch unit, slave = memory/decoder side.
interface fetch_unit_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic              two_word;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr, mem_rd, ir, mdr, two_word, out_valid,
    input  mem_ready, mem_rdata, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd, ir, mdr, two_word, out_valid,
    output mem_ready, mem_rdata, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads opcode (and optional immediate) at the PC, pulses the
// PC increment per word read, and holds IR/MDR for the decoder under valid/ready.
module fetch_unit #(
  parameter int DATA_W       = 16,
  parameter int TWO_WORD_BIT = 15,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pc_val_i,
  output logic              pc_inc_o,
  input  logic              flush_i,
  input  logic              halt_i,
  output logic              halted_o,
  output logic [CNT_W-1:0]  fetch_count_o,
  fetch_unit_if.master      bus
);

  typedef enum logic [1:0] {
    S_IR   = 2'd0,
    S_IMM  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_rd_s;
  logic              rd_done_s;
  logic              out_valid_s;
  logic              halted_s;

  // Next-state, request and handshake decode; rst and flush suppress every side effect.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    cnt_d       = cnt_q;
    mem_rd_s    = 1'b0;
    rd_done_s   = 1'b0;
    out_valid_s = 1'b0;
    halted_s    = 1'b0;
    if (rst) begin
      state_d = S_IR;
    end else if (flush_i) begin
      state_d  = S_IR;
      halted_s = (state_q == S_IR) & halt_i;
    end else begin
      case (state_q)
        S_IR: begin
          mem_rd_s  = ~halt_i;
          halted_s  = halt_i;
          rd_done_s = ~halt_i & bus.mem_ready;
          if (rd_done_s) begin
            ir_d    = bus.mem_rdata;
            state_d = bus.mem_rdata[TWO_WORD_BIT] ? S_IMM : S_HOLD;
          end else begin
            state_d = S_IR;
          end
        end
        S_IMM: begin
          mem_rd_s  = 1'b1;
          rd_done_s = bus.mem_ready;
          if (rd_done_s) begin
            mdr_d   = bus.mem_rdata;
            state_d = S_HOLD;
          end else begin
            state_d = S_IMM;
          end
        end
        S_HOLD: begin
          out_valid_s = 1'b1;
          if (bus.out_ready) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_IR;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: begin
          state_d = S_IR;
        end
      endcase
    end
  end

  // State and holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IR;
      ir_q    <= {DATA_W{1'b0}};
      mdr_q   <= {DATA_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held values are masked during the reset cycle so every output reads zero.
  assign bus.mem_rd     = mem_rd_s;
  assign bus.mem_addr   = rst ? {DATA_W{1'b0}} : pc_val_i;
  assign bus.out_valid  = out_valid_s;
  assign bus.ir         = rst ? {DATA_W{1'b0}} : ir_q;
  assign bus.mdr        = rst ? {DATA_W{1'b0}} : mdr_q;
  assign bus.two_word   = rst ? 1'b0 : ir_q[TWO_WORD_BIT];
  assign pc_inc_o       = rd_done_s;
  assign halted_o       = halted_s;
  assign fetch_count_o  = rst ? {CNT_W{1'b0}} : cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus a randomized run checked against an instruction-stream model.
// The counter is built 8 bits wide so its wrap is reachable in a short run.
module tb_fetch_unit;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, flush, halt, pc_inc, halted;
  logic [DW-1:0] pc_q, new_pc;
  logic [CW-1:0] fetch_count;
  logic [DW-1:0] mem [0:255];
  int            n_cmp = 0;
  int            n_err = 0;

  fetch_unit_if #(.DATA_W(DW)) bus ();

  fetch_unit #(.DATA_W(DW), .TWO_WORD_BIT(15), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc_val_i(pc_q), .pc_inc_o(pc_inc),
    .flush_i(flush), .halt_i(halt), .halted_o(halted),
    .fetch_count_o(fetch_count), .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  // PC register owned by the environment: reset, load on flush, increment on pc_inc.
  always @(posedge clk) begin
    if (rst) pc_q <= 16'h0000;
    else if (flush) pc_q <= new_pc;
    else if (pc_inc) pc_q <= pc_q + 16'h0001;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; halt = 1'b0; new_pc = 16'h0000;
    bus.mem_ready = 1'b0; bus.out_ready = 1'b0;
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; halt = 1'b0; new_pc = 16'h0000;
    bus.mem_ready = 1'b1; bus.out_ready = 1'b1;
    nxt(); #1;
    n_cmp++; if (bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL rst_mem_rd got %0h exp 0", bus.mem_rd); end
    n_cmp++; if (pc_inc !== 1'b0) begin n_err++; $display("FAIL rst_pc_inc got %0h exp 0", pc_inc); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0h exp 0", bus.out_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %0h exp 0", halted); end
    n_cmp++; if (bus.ir !== 16'h0000) begin n_err++; $display("FAIL rst_ir got %h exp 0000", bus.ir); end
    n_cmp++; if (bus.mdr !== 16'h0000) begin n_err++; $display("FAIL rst_mdr got %h exp 0000", bus.mdr); end
    n_cmp++; if (fetch_count !== 8'h00) begin n_err++; $display("FAIL rst_count got %h exp 00", fetch_count); end
    n_cmp++; if (bus.two_word !== 1'b0) begin n_err++; $display("FAIL rst_two_word got %0h exp 0", bus.two_word); end
    nxt();
    rst = 1'b0; bus.mem_ready = 1'b0; bus.out_ready = 1'b0;
  endtask

  task automatic test_one_word();
    mem[0] = 16'h1234; mem[1] = 16'h0042;
    do_reset();
    bus.mem_ready = 1'b1; bus.out_ready = 1'b1; #1;
    n_cmp++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0000) begin n_err++; $display("FAIL ow_req got rd=%0h addr=%h exp rd=1 addr=0000", bus.mem_rd, bus.mem_addr); end
    n_cmp++; if (pc_inc !== 1'b1 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL ow_c0 got inc=%0h vld=%0h exp inc=1 vld=0", pc_inc, bus.out_valid); end
    nxt(); #1;
    n_cmp++; if (bus.ir !== 16'h1234) begin n_err++; $display("FAIL ow_ir got %h exp 1234", bus.ir); end
    n_cmp++; if (bus.out_valid !== 1'b1 || pc_inc !== 1'b0 || bus.mem_rd !== 1'b0) begin n_err++; $display("FAIL ow_hold got vld=%0h inc=%0h rd=%0h exp 1/0/0", bus.out_valid, pc_inc, bus.mem_rd); end
    n_cmp++; if (bus.two_word !== 1'b0) begin n_err++; $display("FAIL ow_two_word got %0h exp 0", bus.two_word); end
    nxt(); #1;
    n_cmp++; if (fetch_count !== 8'h01) begin n_err++; $display("FAIL ow_count got %h exp 01", fetch_count); end
    n_cmp++; if (bus.mem_addr !== 16'h0001 || bus.mem_rd !== 1'b1) begin n_err++; $display("FAIL ow_next_addr got addr=%h rd=%0h exp 0001/1", bus.mem_addr, bus.mem_rd); end
  endtask

  task automatic test_two_word();
    int incs = 0;
    mem[0] = 16'h8005; mem[1] = 16'h00AB; mem[2] = 16'h0007;
    do_reset();
    bus.mem_ready = 1'b1; bus.out_ready = 1'b1; #1;
    if (pc_inc === 1'b1) incs++;
    nxt(); #1;
    if (pc_inc === 1'b1) incs++;
    n_cmp++; if (bus.ir !== 16'h8005) begin n_err++; $display("FAIL tw_ir got %h exp 8005", bus.ir); end
    n_cmp++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0001) begin n_err++; $display("FAIL tw_imm_req got rd=%0h addr=%h exp 1/0001", bus.mem_rd, bus.mem_addr); end
    nxt(); #1;
    if (pc_inc === 1'b1) incs++;
    n_cmp++; if (bus.mdr !== 16'h00AB || bus.two_word !== 1'b1) begin n_err++; $display("FAIL tw_mdr got mdr=%h tw=%0h exp 00AB/1", bus.mdr, bus.two_word); end
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL tw_valid got %0h exp 1", bus.out_valid); end
    n_cmp++; if (incs != 2) begin n_err++; $display("FAIL tw_pc_inc_count got %0d exp 2", incs); end
    nxt(); #1;
    n_cmp++; if (fetch_count !== 8'h01 || bus.mem_addr !== 16'h0002) begin n_err++; $display("FAIL tw_cycle3 got cnt=%h addr=%h exp 01/0002", fetch_count, bus.mem_addr); end
  endtask

  task automatic test_wait_states();
    int bad = 0;
    mem[0] = 16'h0321;
    do_reset();
    bus.mem_ready = 1'b0; bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0000 || pc_inc !== 1'b0) bad++;
      nxt();
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ws_wait got %0d bad cycles exp 0", bad); end
    bus.mem_ready = 1'b1; #1;
    n_cmp++; if (pc_inc !== 1'b1 || bus.mem_addr !== 16'h0000) begin n_err++; $display("FAIL ws_done got inc=%0h addr=%h exp 1/0000", pc_inc, bus.mem_addr); end
    nxt();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.ir !== 16'h0321 || bus.out_valid !== 1'b1 || bus.mem_rd !== 1'b0 || pc_inc !== 1'b0) bad++;
      nxt();
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ws_hold got %0d bad cycles exp 0", bad); end
    bus.out_ready = 1'b1;
    nxt(); #1;
    n_cmp++; if (fetch_count !== 8'h01 || bus.mem_addr !== 16'h0001) begin n_err++; $display("FAIL ws_after got cnt=%h addr=%h exp 01/0001", fetch_count, bus.mem_addr); end
  endtask

  task automatic test_flush();
    mem[0] = 16'h8010; mem[1] = 16'h5555; mem[8'h40] = 16'h0099; mem[8'h10] = 16'h0011;
    do_reset();
    bus.mem_ready = 1'b1; bus.out_ready = 1'b0;
    nxt();
    flush = 1'b1; new_pc = 16'h0040; #1;
    n_cmp++; if (pc_inc !== 1'b0 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_imm got inc=%0h vld=%0h exp 0/0", pc_inc, bus.out_valid); end
    nxt();
    flush = 1'b0; #1;
    n_cmp++; if (bus.mdr !== 16'h0000) begin n_err++; $display("FAIL fl_mdr got %h exp 0000", bus.mdr); end
    n_cmp++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0040 || pc_inc !== 1'b1) begin n_err++; $display("FAIL fl_refetch got rd=%0h addr=%h inc=%0h exp 1/0040/1", bus.mem_rd, bus.mem_addr, pc_inc); end
    nxt(); #1;
    n_cmp++; if (bus.ir !== 16'h0099 || bus.mdr !== 16'h0000) begin n_err++; $display("FAIL fl_new_ir got ir=%h mdr=%h exp 0099/0000", bus.ir, bus.mdr); end
    bus.out_ready = 1'b1; flush = 1'b1; new_pc = 16'h0010; #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_hold_valid got %0h exp 0", bus.out_valid); end
    nxt();
    flush = 1'b0; #1;
    n_cmp++; if (fetch_count !== 8'h00 || bus.mem_addr !== 16'h0010) begin n_err++; $display("FAIL fl_hold_after got cnt=%h addr=%h exp 00/0010", fetch_count, bus.mem_addr); end
  endtask

  task automatic test_halt_reset();
    int bad = 0;
    mem[0] = 16'h0777;
    do_reset();
    halt = 1'b1; bus.mem_ready = 1'b1; bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.mem_rd !== 1'b0 || halted !== 1'b1 || pc_inc !== 1'b0) bad++;
      nxt();
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL hr_halted got %0d bad cycles exp 0", bad); end
    halt = 1'b0; #1;
    n_cmp++; if (bus.mem_rd !== 1'b1 || halted !== 1'b0 || pc_inc !== 1'b1) begin n_err++; $display("FAIL hr_release got rd=%0h halted=%0h inc=%0h exp 1/0/1", bus.mem_rd, halted, pc_inc); end
    nxt();
    halt = 1'b1; #1;
    n_cmp++; if (bus.out_valid !== 1'b1 || halted !== 1'b0 || bus.ir !== 16'h0777) begin n_err++; $display("FAIL hr_hold got vld=%0h halted=%0h ir=%h exp 1/0/0777", bus.out_valid, halted, bus.ir); end
    rst = 1'b1; halt = 1'b0; #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL hr_rst_valid got %0h exp 0", bus.out_valid); end
    nxt();
    rst = 1'b0; bus.mem_ready = 1'b0; #1;
    n_cmp++; if (bus.ir !== 16'h0000 || bus.out_valid !== 1'b0) begin n_err++; $display("FAIL hr_rst_after got ir=%h vld=%0h exp 0000/0", bus.ir, bus.out_valid); end
  endtask

  task automatic test_random();
    logic [15:0] exp_addr, a1, step;
    int cnt = 0;
    int hs_bad = 0;
    int rules_bad = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    do_reset();
    exp_addr = 16'h0000;
    for (int c = 0; c < 3000; c++) begin
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      halt = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 63) == 0);
      new_pc = 16'($urandom);
      #1;
      if (bus.mem_rd === 1'b1 && bus.mem_addr !== pc_q) rules_bad++;
      if (halted === 1'b1 && bus.mem_rd !== 1'b0) rules_bad++;
      if (pc_inc === 1'b1 && !(bus.mem_rd === 1'b1 && bus.mem_ready === 1'b1)) rules_bad++;
      if (flush && (bus.out_valid !== 1'b0 || pc_inc !== 1'b0)) rules_bad++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        a1 = exp_addr + 16'h0001;
        step = mem[exp_addr[7:0]][15] ? 16'h0002 : 16'h0001;
        n_cmp++;
        if (bus.ir !== mem[exp_addr[7:0]] || bus.two_word !== mem[exp_addr[7:0]][15]
            || (mem[exp_addr[7:0]][15] && bus.mdr !== mem[a1[7:0]]) || pc_q !== exp_addr + step) begin
          n_err++; hs_bad++;
          $display("FAIL rnd_instr at %h got ir=%h mdr=%h pc=%h exp ir=%h imm=%h pc=%h", exp_addr, bus.ir, bus.mdr, pc_q, mem[exp_addr[7:0]], mem[a1[7:0]], exp_addr + step);
        end
        exp_addr = exp_addr + step;
        cnt++;
      end
      if (flush) exp_addr = new_pc;
      nxt();
      n_cmp++; if (fetch_count !== cnt[CW-1:0]) begin n_err++; $display("FAIL rnd_count got %h exp %h", fetch_count, cnt[CW-1:0]); end
    end
    n_cmp++; if (rules_bad != 0) begin n_err++; $display("FAIL rnd_rules got %0d violations exp 0", rules_bad); end
    n_cmp++; if (cnt < 100) begin n_err++; $display("FAIL rnd_progress got %0d handshakes exp >=100", cnt); end
    flush = 1'b0; halt = 1'b0;
  endtask

  task automatic test_count_wrap();
    int hs = 0;
    int budget = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0001;
    do_reset();
    bus.mem_ready = 1'b1; bus.out_ready = 1'b1;
    while (hs < 255 && budget < 2000) begin
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) hs++;
      nxt();
      budget++;
    end
    n_cmp++; if (hs != 255) begin n_err++; $display("FAIL wrap_budget got %0d handshakes exp 255", hs); end
    n_cmp++; if (fetch_count !== 8'hFF) begin n_err++; $display("FAIL wrap_max got %h exp FF", fetch_count); end
    budget = 0;
    while (hs < 256 && budget < 20) begin
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) hs++;
      nxt();
      budget++;
    end
    n_cmp++; if (fetch_count !== 8'h00 || hs != 256) begin n_err++; $display("FAIL wrap_zero got cnt=%h hs=%0d exp 00/256", fetch_count, hs); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_one_word();
    test_two_word();
    test_wait_states();
    test_flush();
    test_halt_reset();
    test_random();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
